// File: rtl/rx_correlator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : rx_correlator
// Description : Correlates each streamed RX sample window against a +/-1
//               spreading code; one signed result per window.
//               Optional peak tracker enabled by macro RX_CORR_PEAK_EN.
// Revision    : 1.0 - initial release
// ============================================================================

module rx_correlator #(
  parameter int MEMORY_LENGTH = 510,
  parameter int RD_LATENCY    = 2,
  parameter int ACC_W         = 26
) (
  input  logic                    crx_clk,
  input  logic                    rrx_rst_n,
  input  logic                    erx_en,
  input  logic                    new_sample_trig,
  input  logic                    wr_en_RAM,
  input  logic signed [15:0]      data_out_RAM,
  output logic        [8:0]       coeff_addr,
  input  logic                    coeff_bit,
  output logic signed [ACC_W-1:0] corr_out,
  output logic                    corr_valid,
  output logic                    busy,
  output logic                    overrun
`ifdef RX_CORR_PEAK_EN
  ,
  input  logic                    peak_clr,
  output logic        [ACC_W-1:0] peak_val,
  output logic        [15:0]      peak_idx
`endif
);

  localparam int c_CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [c_CNT_W-1:0] c_WAIT_INIT = c_CNT_W'(RD_LATENCY - 1);
  localparam logic [8:0]         c_LAST      = 9'(MEMORY_LENGTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACC  = 2'd2
  } state_t;

  // With a single-cycle read latency the first sample arrives right after the trigger.
  localparam state_t c_START_STATE = (RD_LATENCY == 1) ? S_ACC : S_WAIT;

  state_t                    r_state;
  state_t                    w_next;
  logic                      w_start;
  logic                      w_abort;
  logic                      w_done;
  logic                      w_step;

  logic [c_CNT_W-1:0]        r_wait_cnt;
  logic [8:0]                r_coeff_addr;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [ACC_W-1:0]   r_corr_out;
  logic                      r_corr_valid;
  logic                      r_overrun;

  logic signed [ACC_W-1:0]   w_sample_ext;
  logic signed [ACC_W-1:0]   w_term;
  logic signed [ACC_W-1:0]   w_sum;

  // Negation happens at full accumulator width, so -(-32768) is representable.
  assign w_sample_ext = data_out_RAM;
  assign w_term       = coeff_bit ? w_sample_ext : -w_sample_ext;
  assign w_sum        = r_acc + w_term;

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_abort = 1'b0;
    w_done  = 1'b0;
    if (!erx_en) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (new_sample_trig) begin
            w_start = 1'b1;
            w_next  = c_START_STATE;
          end
        end
        S_WAIT: begin
          if (new_sample_trig) begin
            w_start = 1'b1;
            w_abort = 1'b1;
            w_next  = c_START_STATE;
          end else if (wr_en_RAM) begin
            w_abort = 1'b1;
            w_next  = S_IDLE;
          end else if (r_wait_cnt == c_CNT_W'(1)) begin
            w_next = S_ACC;
          end
        end
        S_ACC: begin
          // The last sample is already consumed, so a trigger here chains windows.
          if (r_coeff_addr == c_LAST) begin
            w_done = 1'b1;
            if (new_sample_trig) begin
              w_start = 1'b1;
              w_next  = c_START_STATE;
            end else begin
              w_next = S_IDLE;
            end
          end else if (new_sample_trig) begin
            w_start = 1'b1;
            w_abort = 1'b1;
            w_next  = c_START_STATE;
          end else if (wr_en_RAM) begin
            w_abort = 1'b1;
            w_next  = S_IDLE;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
    w_step = (r_state == S_ACC) && (w_next == S_ACC) && !w_start;
  end

  always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
    if (!rrx_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
    if (!rrx_rst_n) begin
      r_wait_cnt   <= '0;
      r_coeff_addr <= '0;
      r_acc        <= '0;
      r_corr_out   <= '0;
      r_corr_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_corr_valid <= w_done;
      r_overrun    <= w_abort;
      if (w_done) begin
        r_corr_out <= w_sum;
      end
      if (w_start) begin
        r_acc        <= '0;
        r_coeff_addr <= '0;
        r_wait_cnt   <= c_WAIT_INIT;
      end else if (w_step) begin
        r_acc        <= w_sum;
        r_coeff_addr <= r_coeff_addr + 9'd1;
      end else begin
        r_coeff_addr <= '0;
        if (r_state == S_WAIT) begin
          r_wait_cnt <= r_wait_cnt - c_CNT_W'(1);
        end
      end
    end
  end

  assign coeff_addr = r_coeff_addr;
  assign corr_out   = r_corr_out;
  assign corr_valid = r_corr_valid;
  assign overrun    = r_overrun;
  assign busy       = (r_state != S_IDLE);

`ifdef RX_CORR_PEAK_EN
  logic [15:0]      r_win_cnt;
  logic [ACC_W-1:0] r_peak_val;
  logic [15:0]      r_peak_idx;
  logic [ACC_W-1:0] w_abs;
  logic [ACC_W-1:0] w_base_val;
  logic [15:0]      w_base_cnt;

  // A clear coinciding with a result is applied before that result is judged.
  assign w_abs      = r_corr_out[ACC_W-1] ? -r_corr_out : r_corr_out;
  assign w_base_val = peak_clr ? '0 : r_peak_val;
  assign w_base_cnt = peak_clr ? '0 : r_win_cnt;

  always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
    if (!rrx_rst_n) begin
      r_win_cnt  <= '0;
      r_peak_val <= '0;
      r_peak_idx <= '0;
    end else begin
      r_win_cnt <= r_corr_valid ? w_base_cnt + 16'd1 : w_base_cnt;
      if (r_corr_valid && (w_abs > w_base_val)) begin
        r_peak_val <= w_abs;
        r_peak_idx <= w_base_cnt;
      end else if (peak_clr) begin
        r_peak_val <= '0;
        r_peak_idx <= '0;
      end
    end
  end

  assign peak_val = r_peak_val;
  assign peak_idx = r_peak_idx;
`endif

endmodule

`default_nettype wire
